// File: rtl/dsp_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// dsp_accumulator_pkg
// Shared definitions for the DSP multiplier / accumulator datapath:
//   - LANE_W      : width of one half-lane (products are 2*LANE_W wide)
//   - mode_e      : MODE_DUAL (two independent lanes) / MODE_SINGLE (one lane)
//   - OVF_LO/HI   : bit positions inside the 2-bit sticky overflow vector
// -----------------------------------------------------------------------------
package dsp_accumulator_pkg;

  localparam int LANE_W = 37;

  typedef enum logic {
    MODE_DUAL   = 1'b0,  // {hi, lo} lanes, 18x19 products
    MODE_SINGLE = 1'b1   // one full-width lane, 27x27 product
  } mode_e;

  localparam int OVF_LO = 0;  // lo lane, or full width in MODE_SINGLE
  localparam int OVF_HI = 1;  // hi lane, MODE_DUAL only

endpackage

// File: rtl/dsp_lane_adder.sv
// -----------------------------------------------------------------------------
// dsp_lane_adder
// One W-bit accumulator lane: sum = load ? addend : acc + addend + carry_in.
// Ports:
//   acc       in  W   current accumulator lane value
//   addend    in  W   incoming product lane
//   carry_in  in  1   carry from the lane below (0 when lanes are independent)
//   load      in  1   replace instead of add
//   sum       out W   next accumulator lane value
//   carry_out out 1   carry out of the lane add (0 on load)
// -----------------------------------------------------------------------------
module dsp_lane_adder #(
  parameter int W = 37
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] addend,
  input  logic         carry_in,
  input  logic         load,
  output logic [W-1:0] sum,
  output logic         carry_out
);

  logic [W:0] total;

  // NOTE: every output of a combinational block is assigned on all paths
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    total     = {1'b0, acc} + {1'b0, addend} + {{W{1'b0}}, carry_in};
    sum       = total[W-1:0];
    carry_out = total[W];
    if (load) begin
      sum       = addend;
      carry_out = 1'b0;
    end
  end

endmodule

// File: rtl/dsp_accumulator.sv
// -----------------------------------------------------------------------------
// dsp_accumulator
// Two-stage accumulator behind a DSP multiplier. Stage 1 captures a product
// beat; stage 2 adds it into the accumulator (or loads it). In dual mode the
// two LANE_W halves accumulate independently; in single mode the carry of the
// lo half chains into the hi half. Valid/ready handshakes on both sides.
// Ports:
//   clk        in   1         clock, rising edge
//   rst_n      in   1         asynchronous active-low reset
//   in_valid   in   1         product beat present
//   in_ready   out  1         beat can be accepted this cycle
//   product    in   2*LANE_W  {hi, lo} (dual) or full-width value (single)
//   mode       in   1         0 = dual lane, 1 = single lane
//   acc_clear  in   1         beat loads instead of adding
//   out_valid  out  1         result holds a valid accumulation
//   out_ready  in   1         downstream accepts the result
//   result     out  2*LANE_W  accumulator value after the beat
//   overflow   out  2         sticky carry flags {hi, lo/full}
// -----------------------------------------------------------------------------
module dsp_accumulator
  import dsp_accumulator_pkg::*;
#(
  parameter int LANE_W = dsp_accumulator_pkg::LANE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*LANE_W-1:0]   product,
  input  logic                  mode,
  input  logic                  acc_clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*LANE_W-1:0]   result,
  output logic [1:0]            overflow
);

  localparam int W = 2 * LANE_W;

  // Stage 1
  logic          s1_valid_q, s1_valid_d;
  logic [W-1:0]  s1_product_q;
  mode_e         s1_mode_q;
  logic          s1_clear_q;

  // Stage 2 / accumulator
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [1:0]    ovf_q, ovf_d;
  mode_e         last_mode_q, last_mode_d;
  logic          seen_q, seen_d;  // a beat has been accumulated since reset

  logic          advance;
  logic          accept;
  logic          update;
  logic          load;
  logic          hi_carry_in;
  logic [LANE_W-1:0] lo_sum, hi_sum;
  logic          lo_carry, hi_carry;
  logic [1:0]    ovf_new;

  // Output register can take a new value when empty or being drained.
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || advance;
  assign accept   = in_valid && in_ready;
  assign update   = s1_valid_q && advance;

  // A mode change invalidates the accumulator layout, so it forces a load.
  assign load = s1_clear_q || !seen_q || (s1_mode_q != last_mode_q);

  assign hi_carry_in = (s1_mode_q == MODE_SINGLE) ? lo_carry : 1'b0;

  dsp_lane_adder #(.W(LANE_W)) u_lane_lo (
    .acc       (acc_q[LANE_W-1:0]),
    .addend    (s1_product_q[LANE_W-1:0]),
    .carry_in  (1'b0),
    .load      (load),
    .sum       (lo_sum),
    .carry_out (lo_carry)
  );

  dsp_lane_adder #(.W(LANE_W)) u_lane_hi (
    .acc       (acc_q[W-1:LANE_W]),
    .addend    (s1_product_q[W-1:LANE_W]),
    .carry_in  (hi_carry_in),
    .load      (load),
    .sum       (hi_sum),
    .carry_out (hi_carry)
  );

  // In single mode the hi carry is the full-width carry and reports on bit0.
  always_comb begin
    ovf_new = 2'b00;
    if (s1_mode_q == MODE_SINGLE) begin
      ovf_new[OVF_LO] = hi_carry;
    end else begin
      ovf_new[OVF_LO] = lo_carry;
      ovf_new[OVF_HI] = hi_carry;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    last_mode_d = last_mode_q;
    seen_d      = seen_q;

    if (accept) begin
      s1_valid_d = 1'b1;
    end else if (update) begin
      s1_valid_d = 1'b0;
    end

    if (update) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (update) begin
      acc_d       = {hi_sum, lo_sum};
      ovf_d       = (load ? 2'b00 : ovf_q) | ovf_new;
      last_mode_d = s1_mode_q;
      seen_d      = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its input from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 2'b00;
      last_mode_q <= MODE_DUAL;
      seen_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      last_mode_q <= last_mode_d;
      seen_q      <= seen_d;
    end
  end

  // NOTE: stage-1 data is left without reset; it is only ever consumed while
  // s1_valid_q is set, which is reset, so the flops can stay cheap.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_product_q <= product;
      s1_mode_q    <= mode_e'(mode);
      s1_clear_q   <= acc_clear;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = acc_q;
  assign overflow  = ovf_q;

endmodule
